// File: rtl/crop_window_ctrl.sv
// crop_window_ctrl -- windowed dark-pixel bounding-box measurement over N frames with valid/ack hand-off.
// Rev 1.0
`default_nettype none

module crop_window_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int DATA_W     = 10,
    parameter int DARK_LEVEL = 0,
    parameter int NUM_FRAMES = 4
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iDVAL,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iCFG_WE,
    input  logic [1:0]        iCFG_ADDR,
    input  logic [15:0]       iCFG_WDATA,
    input  logic              iSTART,
    input  logic              iABORT,
    input  logic              iRES_ACK,
    output logic              oBUSY,
    output logic              oRES_VALID,
    output logic              oFOUND,
    output logic [15:0]       oXSTART,
    output logic [15:0]       oXEND,
    output logic [15:0]       oYSTART,
    output logic [15:0]       oYEND,
    output logic [7:0]        oFRAME_CNT
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_ARM     = 2'd1;
    localparam logic [1:0]  S_MEASURE = 2'd2;
    localparam logic [1:0]  S_REPORT  = 2'd3;
    localparam logic [15:0] X_LAST    = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST    = 16'(V_ACTIVE - 1);
    localparam logic [7:0]  FRAMES    = 8'(NUM_FRAMES);
    localparam logic [DATA_W-1:0] DARK_MAX = DATA_W'(DARK_LEVEL);

    logic [1:0]  state, state_nxt;
    logic [15:0] x_cnt, y_cnt;
    logic [15:0] win_x0, win_x1, win_y0, win_y1;
    logic [15:0] sh_x0, sh_x1, sh_y0, sh_y1;
    logic [15:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [15:0] xmin_nxt, xmax_nxt, ymin_nxt, ymax_nxt;
    logic        acc_found, found_nxt;
    logic        eof, hit, in_win, start_go, last_frame;

    assign eof        = iDVAL && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign in_win     = (x_cnt > sh_x0) && (x_cnt < sh_x1) && (y_cnt > sh_y0) && (y_cnt < sh_y1);
    assign hit        = (state == S_MEASURE) && iDVAL && (iDATA <= DARK_MAX) && in_win;
    assign start_go   = (state == S_IDLE) && iSTART && !iABORT;
    assign last_frame = eof && ((oFRAME_CNT + 8'd1) == FRAMES);

    // Raster position tracks the stream regardless of FSM state.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (iDVAL) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? 16'd0 : y_cnt + 16'd1;
            end else begin
                x_cnt <= x_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            win_x0 <= 16'd160;
            win_x1 <= 16'd480;
            win_y0 <= 16'd120;
            win_y1 <= 16'd190;
            sh_x0  <= 16'd160;
            sh_x1  <= 16'd480;
            sh_y0  <= 16'd120;
            sh_y1  <= 16'd190;
        end else begin
            if ((state == S_IDLE) && iCFG_WE) begin
                case (iCFG_ADDR)
                    2'd0:    win_x0 <= iCFG_WDATA;
                    2'd1:    win_x1 <= iCFG_WDATA;
                    2'd2:    win_y0 <= iCFG_WDATA;
                    default: win_y1 <= iCFG_WDATA;
                endcase
            end
            if (start_go) begin
                sh_x0 <= win_x0;
                sh_x1 <= win_x1;
                sh_y0 <= win_y0;
                sh_y1 <= win_y1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_go) state_nxt = S_ARM;
            S_ARM:     if (iABORT) state_nxt = S_IDLE;
                       else if (eof) state_nxt = S_MEASURE;
            S_MEASURE: if (iABORT) state_nxt = S_IDLE;
                       else if (last_frame) state_nxt = S_REPORT;
            default:   if (iABORT || iRES_ACK) state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        oBUSY      = (state != S_IDLE);
        oRES_VALID = (state == S_REPORT);
    end

    always_comb begin
        xmin_nxt  = (hit && (x_cnt < acc_xmin)) ? x_cnt : acc_xmin;
        xmax_nxt  = (hit && (x_cnt > acc_xmax)) ? x_cnt : acc_xmax;
        ymin_nxt  = (hit && (y_cnt < acc_ymin)) ? y_cnt : acc_ymin;
        ymax_nxt  = (hit && (y_cnt > acc_ymax)) ? y_cnt : acc_ymax;
        found_nxt = acc_found | hit;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            acc_xmin  <= '0;
            acc_xmax  <= '0;
            acc_ymin  <= '0;
            acc_ymax  <= '0;
            acc_found <= 1'b0;
        end else if ((state == S_ARM) && eof) begin
            acc_xmin  <= 16'hFFFF;
            acc_xmax  <= 16'h0000;
            acc_ymin  <= 16'hFFFF;
            acc_ymax  <= 16'h0000;
            acc_found <= 1'b0;
        end else if (state == S_MEASURE) begin
            acc_xmin  <= xmin_nxt;
            acc_xmax  <= xmax_nxt;
            acc_ymin  <= ymin_nxt;
            acc_ymax  <= ymax_nxt;
            acc_found <= found_nxt;
        end
    end

    // Results load from the next-values so a hit on the final EOF pixel is kept.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oFRAME_CNT <= '0;
            oFOUND     <= 1'b0;
            oXSTART    <= '0;
            oXEND      <= '0;
            oYSTART    <= '0;
            oYEND      <= '0;
        end else begin
            if (start_go) begin
                oFRAME_CNT <= '0;
            end else if ((state == S_MEASURE) && eof && !iABORT) begin
                oFRAME_CNT <= oFRAME_CNT + 8'd1;
            end
            if ((state == S_MEASURE) && last_frame && !iABORT) begin
                oFOUND  <= found_nxt;
                oXSTART <= found_nxt ? xmin_nxt : 16'd0;
                oXEND   <= found_nxt ? xmax_nxt : 16'd0;
                oYSTART <= found_nxt ? ymin_nxt : 16'd0;
                oYEND   <= found_nxt ? ymax_nxt : 16'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_crop_window_ctrl.sv
// tb_crop_window_ctrl -- directed bench for crop_window_ctrl on a reduced 20x12 raster.
// Rev 1.0
`default_nettype none

module tb_crop_window_ctrl;

    localparam int H = 20;
    localparam int V = 12;

    logic        iCLK, iRST, iDVAL, iCFG_WE, iSTART, iABORT, iRES_ACK;
    logic [9:0]  iDATA;
    logic [1:0]  iCFG_ADDR;
    logic [15:0] iCFG_WDATA;
    logic        oBUSY, oRES_VALID, oFOUND;
    logic [15:0] oXSTART, oXEND, oYSTART, oYEND;
    logic [7:0]  oFRAME_CNT;

    int checks   = 0;
    int failures = 0;
    int bx = 0, by = 0, bframe = 0, f0 = 0;
    int dk_f[8], dk_x[8], dk_y[8];
    int dk_n = 0;

    crop_window_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(10), .DARK_LEVEL(0), .NUM_FRAMES(4)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iDATA(iDATA),
        .iCFG_WE(iCFG_WE), .iCFG_ADDR(iCFG_ADDR), .iCFG_WDATA(iCFG_WDATA),
        .iSTART(iSTART), .iABORT(iABORT), .iRES_ACK(iRES_ACK),
        .oBUSY(oBUSY), .oRES_VALID(oRES_VALID), .oFOUND(oFOUND),
        .oXSTART(oXSTART), .oXEND(oXEND), .oYSTART(oYSTART), .oYEND(oYEND),
        .oFRAME_CNT(oFRAME_CNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic f, input int xs, input int xe,
                           input int ys, input int ye);
        chk(tag, {oRES_VALID, oFOUND, oXSTART, oXEND, oYSTART, oYEND},
            {1'b1, f, 16'(xs), 16'(xe), 16'(ys), 16'(ye)});
    endtask

    function automatic bit is_dark(input int x, input int y, input int f);
        for (int i = 0; i < dk_n; i++)
            if ((dk_f[i] < 0 || dk_f[i] == f) && dk_x[i] == x && dk_y[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_dark(input int f, input int x, input int y);
        dk_f[dk_n] = f; dk_x[dk_n] = x; dk_y[dk_n] = y;
        dk_n++;
    endtask

    // Bright pixels use value 1, just above the dark threshold.
    task automatic pix();
        iDVAL = 1'b1;
        iDATA = is_dark(bx, by, bframe) ? 10'd0 : 10'd1;
        @(posedge iCLK); #1;
        iDVAL = 1'b0;
        if (bx == H - 1) begin
            bx = 0;
            if (by == V - 1) begin by = 0; bframe++; end
            else by++;
        end else bx++;
    endtask

    task automatic idle();
        iDVAL = 1'b0;
        @(posedge iCLK); #1;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [15:0] d);
        iCFG_WE = 1'b1; iCFG_ADDR = a; iCFG_WDATA = d;
        pix();
        iCFG_WE = 1'b0;
    endtask

    task automatic start();
        iSTART = 1'b1;
        f0 = bframe;
        pix();
        iSTART = 1'b0;
    endtask

    task automatic ack();
        iRES_ACK = 1'b1;
        pix();
        iRES_ACK = 1'b0;
        chk("ack_to_idle", {oRES_VALID, oBUSY}, 2'b00);
    endtask

    // Valid must appear right after an EOF pixel, i.e. with the bench back at (0,0).
    task automatic run_to_valid(input string tag);
        int n = 0;
        while (!oRES_VALID && n < 6 * H * V) begin
            if (n % 37 == 36) idle();
            else pix();
            n++;
        end
        chk({tag, "_valid"}, oRES_VALID, 1'b1);
        chk({tag, "_latency"}, {16'(bx), 16'(by)}, 32'd0);
        chk({tag, "_frames"}, {16'(bframe - f0), oFRAME_CNT}, {16'd5, 8'd4});
    endtask

    initial begin
        iRST = 1'b0; iDVAL = 1'b0; iDATA = '0; iCFG_WE = 1'b0; iCFG_ADDR = '0;
        iCFG_WDATA = '0; iSTART = 1'b0; iABORT = 1'b0; iRES_ACK = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        chk("reset_outs", {oBUSY, oRES_VALID, oFOUND, oXSTART, oXEND, oYSTART, oYEND, oFRAME_CNT}, '0);
        iRST = 1'b1;

        // Single pixel; a dark pixel in the partial arming frame is ignored.
        cfg(2'd0, 16'd4); cfg(2'd1, 16'd15); cfg(2'd2, 16'd3); cfg(2'd3, 16'd9);
        repeat (100) pix();
        add_dark(0, 7, 6);
        add_dark(1, 9, 5);
        start();
        chk("arm_busy", {oBUSY, oRES_VALID}, 2'b10);
        run_to_valid("single");
        chk_res("single_res", 1'b1, 9, 9, 5, 5);

        // Held result with iSTART pulses, then ack.
        for (int i = 0; i < 100; i++) begin
            iSTART = (i % 10 == 0);
            pix();
            iSTART = 1'b0;
            chk_res("hold_res", 1'b1, 9, 9, 5, 5);
        end
        ack();
        chk("ack_keep_res", {oFOUND, oXSTART, oXEND, oYSTART, oYEND}, {1'b1, 16'd9, 16'd9, 16'd5, 16'd5});

        iSTART = 1'b1; iABORT = 1'b1;
        pix();
        iSTART = 1'b0; iABORT = 1'b0;
        chk("start_abort_idle", oBUSY, 1'b0);

        // Union of frames 1 and 3.
        dk_n = 0;
        add_dark(bframe + 1, 5, 4);
        add_dark(bframe + 3, 13, 8);
        start();
        run_to_valid("union");
        chk_res("union_res", 1'b1, 5, 13, 4, 8);
        ack();

        // Pixels on the window edges are outside the strict window.
        dk_n = 0;
        add_dark(-1, 4, 5); add_dark(-1, 15, 5); add_dark(-1, 10, 3); add_dark(-1, 10, 9);
        start();
        run_to_valid("edges");
        chk_res("edges_res", 1'b0, 0, 0, 0, 0);
        ack();

        // Full window; hit on the EOF pixel counts; write during MEASURE ignored.
        cfg(2'd0, 16'd0); cfg(2'd1, 16'd20); cfg(2'd2, 16'd0); cfg(2'd3, 16'd12);
        dk_n = 0;
        add_dark(-1, 1, 6); add_dark(-1, 19, 11); add_dark(-1, 0, 6); add_dark(-1, 5, 0);
        start();
        while (bframe < f0 + 1) pix();
        cfg(2'd0, 16'd15);
        chk("measure_busy", oBUSY, 1'b1);
        run_to_valid("full");
        chk_res("full_res", 1'b1, 1, 19, 6, 11);
        ack();
        start();
        run_to_valid("full2");
        chk_res("full2_res", 1'b1, 1, 19, 6, 11);
        ack();

        // Abort mid-measurement keeps the previous result.
        dk_n = 0;
        add_dark(-1, 2, 2);
        start();
        while (bframe < f0 + 2) pix();
        repeat (50) pix();
        iABORT = 1'b1;
        pix();
        iABORT = 1'b0;
        chk("abort_state", {oBUSY, oRES_VALID, oFRAME_CNT}, {1'b0, 1'b0, 8'd1});
        chk("abort_keep_res", {oFOUND, oXSTART, oXEND, oYSTART, oYEND}, {1'b1, 16'd1, 16'd19, 16'd6, 16'd11});

        // Asynchronous reset mid-frame.
        start();
        repeat (300) pix();
        iRST = 1'b0;
        #2;
        chk("async_reset_outs", {oBUSY, oRES_VALID, oFOUND, oXSTART, oXEND, oYSTART, oYEND, oFRAME_CNT}, '0);
        @(posedge iCLK); #1;
        iRST = 1'b1;
        bx = 0; by = 0;

        // Default window lies outside the reduced raster, so nothing matches.
        dk_n = 0;
        add_dark(-1, 9, 5);
        start();
        run_to_valid("post_rst_default");
        chk_res("post_rst_default_res", 1'b0, 0, 0, 0, 0);
        ack();
        cfg(2'd0, 16'd4); cfg(2'd1, 16'd15); cfg(2'd2, 16'd3); cfg(2'd3, 16'd9);
        start();
        run_to_valid("post_rst");
        chk_res("post_rst_res", 1'b1, 9, 9, 5, 5);
        ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
